// File: rtl/hazard_tracker_pkg.sv
// Shared widths, instruction field positions and mult/div timing defaults
// for the MIPS operand-forwarding producer side.
package mips_hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int REG_W  = 5;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef logic [REG_W-1:0]  reg_addr_t;
    typedef logic [TNEW_W-1:0] tnew_t;

    typedef struct packed {
        reg_addr_t a3;
        tnew_t     tnew;
    } stage_t;

    // Remaining latency shrinks by one per stage but never wraps below zero.
    function automatic tnew_t tnew_dec(input tnew_t t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// D-stage request and E/M/W producer bundle between the pipeline and the hazard tracker.
// HAZARD_STATS_EN adds the stall_cnt statistics signal.
interface hazard_tracker_if;

    logic [31:0]                 IR_D;
    logic                        rs_used;
    logic                        rt_used;
    mips_hazard_pkg::tnew_t      Tuse_rs;
    mips_hazard_pkg::tnew_t      Tuse_rt;
    mips_hazard_pkg::reg_addr_t  A3_D;
    mips_hazard_pkg::tnew_t      Tnew_D;
    logic                        md_use_D;
    logic                        md_start;
    logic                        md_is_div;

    logic                        stall;
    mips_hazard_pkg::reg_addr_t  A3_E;
    mips_hazard_pkg::reg_addr_t  A3_M;
    mips_hazard_pkg::reg_addr_t  A3_W;
    mips_hazard_pkg::tnew_t      Tnew_E;
    mips_hazard_pkg::tnew_t      Tnew_M;
    mips_hazard_pkg::tnew_t      Tnew_W;
    logic                        md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]                 stall_cnt;
`endif

    modport master (
        output IR_D, rs_used, rt_used, Tuse_rs, Tuse_rt, A3_D, Tnew_D,
               md_use_D, md_start, md_is_div,
        input  stall, A3_E, A3_M, A3_W, Tnew_E, Tnew_M, Tnew_W, md_busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  IR_D, rs_used, rt_used, Tuse_rs, Tuse_rt, A3_D, Tnew_D,
               md_use_D, md_start, md_is_div,
        output stall, A3_E, A3_M, A3_W, Tnew_E, Tnew_M, Tnew_W, md_busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/hazard_tracker_md_busy_timer.sv
// Occupancy timer for the multicycle mult/div unit; a new issue always reloads.
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (md_start) begin
            count <= md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign md_busy = (count != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Carries A3/Tnew through E/M/W and raises stall on unforwardable operands or HI/LO use.
// Define HAZARD_STATS_EN to add the stall_cnt cycle counter.
module hazard_tracker
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    hazard_tracker_if.slave  hz
);

    stage_t    e_q, m_q, w_q;
    reg_addr_t rs, rt;
    logic      data_stall, md_stall, stall;
    logic      md_busy;

    assign rs = hz.IR_D[RS_HI:RS_LO];
    assign rt = hz.IR_D[RT_HI:RT_LO];

    // A producer blocks a reader only if its value is still further away than the reader's need.
    function automatic logic needs_stall(input reg_addr_t src, input logic used,
                                         input tnew_t tuse, input stage_t st);
        return used && (src != '0) && (src == st.a3) && (st.tnew > tuse);
    endfunction

    always_comb begin
        data_stall = needs_stall(rs, hz.rs_used, hz.Tuse_rs, e_q)
                   | needs_stall(rs, hz.rs_used, hz.Tuse_rs, m_q)
                   | needs_stall(rs, hz.rs_used, hz.Tuse_rs, w_q)
                   | needs_stall(rt, hz.rt_used, hz.Tuse_rt, e_q)
                   | needs_stall(rt, hz.rt_used, hz.Tuse_rt, m_q)
                   | needs_stall(rt, hz.rt_used, hz.Tuse_rt, w_q);
        md_stall   = hz.md_use_D & (md_busy | hz.md_start);
        stall      = data_stall | md_stall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q      <= stall ? stage_t'('0) : stage_t'{a3: hz.A3_D, tnew: hz.Tnew_D};
            m_q.a3   <= e_q.a3;
            m_q.tnew <= tnew_dec(e_q.tnew);
            w_q.a3   <= m_q.a3;
            w_q.tnew <= tnew_dec(m_q.tnew);
        end
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .md_start  (hz.md_start),
        .md_is_div (hz.md_is_div),
        .md_busy   (md_busy)
    );

    assign hz.stall   = stall;
    assign hz.A3_E    = e_q.a3;
    assign hz.A3_M    = m_q.a3;
    assign hz.A3_W    = w_q.a3;
    assign hz.Tnew_E  = e_q.tnew;
    assign hz.Tnew_M  = m_q.tnew;
    assign hz.Tnew_W  = w_q.tnew;
    assign hz.md_busy = md_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule
